// File: rtl/l2_cacheline_adaptor_pkg.sv
// l2_pkg: shared types and sizing for the L2 cache-line <-> burst adaptor.
//   LINE_BITS     : cache line width (256)
//   BURST_BITS    : DRAM burst beat width (64)
//   NUM_BEATS     : beats per line (4)
//   BEAT_IDX_BITS : beat counter width (2)
//   adaptor_state_e : IDLE / READ / WRITE / DONE
//   line_align()  : drops the byte-in-line offset of an address
package l2_pkg;
  localparam int LINE_BITS     = 256;
  localparam int BURST_BITS    = 64;
  localparam int NUM_BEATS     = LINE_BITS / BURST_BITS;
  localparam int BEAT_IDX_BITS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_e;

  // 32-byte lines: the low five address bits select a byte inside the line.
  function automatic logic [31:0] line_align(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction
endpackage

// File: rtl/l2_cacheline_adaptor_if.sv
// l2_cacheline_adaptor_if: bundles the L2 line-side request/response and the
// DRAM-side burst signals of the adaptor.
//   slave  modport : the adaptor's view (line requests in, bursts out)
//   master modport : the environment's view (L2 + memory model)
// Optional macro L2_ADAPTOR_TIMEOUT_EN adds the burst_timeout signal.
interface l2_cacheline_adaptor_if;
  import l2_pkg::*;

  logic [31:0]           line_address;
  logic                  line_read;
  logic                  line_write;
  logic [LINE_BITS-1:0]  line_wdata;
  logic [LINE_BITS-1:0]  line_rdata;
  logic                  line_resp;
  logic [31:0]           burst_address;
  logic                  burst_read;
  logic                  burst_write;
  logic [BURST_BITS-1:0] burst_wdata;
  logic [BURST_BITS-1:0] burst_rdata;
  logic                  burst_resp;
`ifdef L2_ADAPTOR_TIMEOUT_EN
  logic                  burst_timeout;
`endif

  modport slave (
    input  line_address, line_read, line_write, line_wdata,
    output line_rdata, line_resp,
    output burst_address, burst_read, burst_write, burst_wdata,
    input  burst_rdata, burst_resp
`ifdef L2_ADAPTOR_TIMEOUT_EN
    , output burst_timeout
`endif
  );

  modport master (
    output line_address, line_read, line_write, line_wdata,
    input  line_rdata, line_resp,
    input  burst_address, burst_read, burst_write, burst_wdata,
    output burst_rdata, burst_resp
`ifdef L2_ADAPTOR_TIMEOUT_EN
    , input burst_timeout
`endif
  );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// l2_cacheline_adaptor: converts one 256-bit L2 line read/write into a 4-beat
// 64-bit burst on the DRAM side, then signals completion with a one-cycle
// line_resp.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : l2_cacheline_adaptor_if.slave (line side + burst side)
// Optional macro L2_ADAPTOR_TIMEOUT_EN: adds parameter timeout_cycles and the
// burst_timeout output; a transaction with no beat for timeout_cycles cycles
// is forced to complete, with partial read data left in line_rdata.
module l2_cacheline_adaptor
  import l2_pkg::*;
`ifdef L2_ADAPTOR_TIMEOUT_EN
  #(parameter int timeout_cycles = 255)
`endif
  (
  input logic             clk,
  input logic             rst,
  l2_cacheline_adaptor_if.slave bus
);

  adaptor_state_e                         state, nstate;
  logic [BEAT_IDX_BITS-1:0]               cnt;
  logic [31:0]                            addr_q;
  logic [NUM_BEATS-1:0][BURST_BITS-1:0]   wline_q;
  logic [NUM_BEATS-1:0][BURST_BITS-1:0]   rline_q;
  logic                                   last_beat;
  logic                                   timeout_hit;
  logic                                   burst_read_c, burst_write_c, line_resp_c;
  logic [BURST_BITS-1:0]                  burst_wdata_c;
  logic                                   unused_addr_lsbs;

  // Byte offset within the line never reaches the DRAM side.
  assign unused_addr_lsbs = ^bus.line_address[4:0];

  assign last_beat = bus.burst_resp && (cnt == BEAT_IDX_BITS'(NUM_BEATS - 1));

`ifdef L2_ADAPTOR_TIMEOUT_EN
  localparam int TW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);

  logic [TW-1:0] tcnt;
  logic          to_q;
  logic          in_burst;

  assign in_burst = (state == READ) || (state == WRITE);
  // tcnt counts stall cycles since the last beat (or since entering the burst);
  // the burst gives up after timeout_cycles consecutive beat-less cycles.
  assign timeout_hit = in_burst && !bus.burst_resp &&
                       (tcnt == TW'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
      to_q <= 1'b0;
    end else begin
      to_q <= timeout_hit;       // high exactly during the DONE it caused
      if (!in_burst || bus.burst_resp) tcnt <= '0;
      else                             tcnt <= tcnt + 1'b1;
    end
  end

  assign bus.burst_timeout = to_q;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  // Next-state logic; a write beats a simultaneous read (writeback before fill).
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (bus.line_write)     nstate = WRITE;
             else if (bus.line_read) nstate = READ;
      READ,
      WRITE: if (last_beat || timeout_hit) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Datapath: address/line capture, beat counter, read-line assembly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.line_write || bus.line_read) begin
          addr_q <= line_align(bus.line_address);
          cnt    <= '0;
          if (bus.line_write) wline_q <= bus.line_wdata;
        end
        READ: if (bus.burst_resp) begin
          rline_q[cnt] <= bus.burst_rdata;
          cnt          <= cnt + 1'b1;   // wraps to 0 after the last beat
        end
        WRITE: if (bus.burst_resp) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state only, so they change right after
  // the clock edge (and drop at once on reset).
  always_comb begin
    burst_read_c  = 1'b0;
    burst_write_c = 1'b0;
    line_resp_c   = 1'b0;
    burst_wdata_c = '0;
    unique case (state)
      READ:  burst_read_c = 1'b1;
      WRITE: begin
        burst_write_c = 1'b1;
        burst_wdata_c = wline_q[cnt];
      end
      DONE:  line_resp_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.burst_read    = burst_read_c;
  assign bus.burst_write   = burst_write_c;
  assign bus.burst_wdata   = burst_wdata_c;
  assign bus.line_resp     = line_resp_c;
  assign bus.burst_address = addr_q;
  assign bus.line_rdata    = rline_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// tb_l2_cacheline_adaptor: table-driven directed transactions, hand-written
// reset/timeout sequences and randomized transactions against a small
// line-level model of l2_cacheline_adaptor.
module tb_l2_cacheline_adaptor;
  import l2_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l2_cacheline_adaptor_if bus();

`ifdef L2_ADAPTOR_TIMEOUT_EN
  l2_cacheline_adaptor #(.timeout_cycles(8)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  l2_cacheline_adaptor dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int nchk = 0;
  int nerr = 0;
  logic [255:0] model_rdata;   // what line_rdata should currently hold

  typedef struct {
    logic             rd;
    logic             wr;
    logic [31:0]      addr;
    logic [255:0]     wline;
    logic [3:0][63:0] rbeats;
    logic [3:0][3:0]  gaps;      // stall cycles before beat k
    logic [31:0]      exp_addr;
    logic [255:0]     exp_rdata;
  } vec_t;

  vec_t tbl[3];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one complete line transaction, checking every cycle.
  // Request is presented in an IDLE cycle; edge 0 samples it.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [3:0][63:0] rbeats,
                        input logic [3:0][3:0] gaps, input logic [31:0] exp_addr);
    logic is_rd;
    is_rd = rd & ~wr;
    chk("idle_line_resp", bus.line_resp, 0);
    bus.line_read    = rd;
    bus.line_write   = wr;
    bus.line_address = addr;
    bus.line_wdata   = wline;
    // Beat responses outside a burst must be ignored.
    bus.burst_resp   = 1'($urandom_range(0, 1));
    bus.burst_rdata  = {$urandom, $urandom};
    tick;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[k]); g++) begin
        bus.burst_resp  = 1'b0;
        bus.burst_rdata = {$urandom, $urandom};
        chk("stall_burst_read", bus.burst_read, is_rd);
        chk("stall_burst_write", bus.burst_write, wr);
        chk("stall_line_resp", bus.line_resp, 0);
        tick;
      end
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = rbeats[k];
      chk("burst_read", bus.burst_read, is_rd);
      chk("burst_write", bus.burst_write, wr);
      chk("beat_line_resp", bus.line_resp, 0);
      chk("burst_address", bus.burst_address, exp_addr);
      if (wr) chk("burst_wdata", bus.burst_wdata, wline[k*64 +: 64]);
      tick;
    end
    // DONE cycle
    bus.burst_resp  = 1'($urandom_range(0, 1));
    bus.burst_rdata = {$urandom, $urandom};
    bus.line_read   = 1'b0;
    bus.line_write  = 1'b0;
    chk("done_line_resp", bus.line_resp, 1);
    chk("done_burst_read", bus.burst_read, 0);
    chk("done_burst_write", bus.burst_write, 0);
    if (is_rd)
      for (int k = 0; k < 4; k++) model_rdata[k*64 +: 64] = rbeats[k];
    chk("done_line_rdata", bus.line_rdata, model_rdata);
`ifdef L2_ADAPTOR_TIMEOUT_EN
    chk("done_no_timeout", bus.burst_timeout, 0);
`endif
    tick;
    bus.burst_resp = 1'b0;
    chk("resp_one_cycle", bus.line_resp, 0);
    chk("rdata_hold", bus.line_rdata, model_rdata);
  endtask

  initial begin
    logic [255:0]     rl;
    logic [3:0][63:0] rb;
    logic [3:0][3:0]  gp;
    logic [31:0]      ra;
    int               op;

    tbl[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h8000_0047, wline: '0,
               rbeats: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               gaps: 16'h0000, exp_addr: 32'h8000_0040,
               exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    tbl[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h1234_5678,
               wline: 256'h0123456789ABCDEF_0011223344556677_8899AABBCCDDEEFF_FEDCBA987654ABCD,
               rbeats: {4{64'hDEAD_BEEF_0000_0000}},
               gaps: 16'h0200, exp_addr: 32'h1234_5660,
               exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
    tbl[2] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_1FFF,
               wline: 256'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C_0F0F0F0F_F0F0F0F0_12121212_34343434,
               rbeats: {4{64'hBAD0_BAD0_BAD0_BAD0}},
               gaps: 16'h1010, exp_addr: 32'h0000_1FE0,
               exp_rdata: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};

    bus.line_read    = 1'b0;
    bus.line_write   = 1'b0;
    bus.line_address = '0;
    bus.line_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
    model_rdata      = '0;

    // Reset state
    #12;
    chk("rst_line_resp", bus.line_resp, 0);
    chk("rst_burst_read", bus.burst_read, 0);
    chk("rst_burst_write", bus.burst_write, 0);
    chk("rst_burst_wdata", bus.burst_wdata, 0);
    chk("rst_burst_address", bus.burst_address, 0);
    chk("rst_line_rdata", bus.line_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    tick;

    // Directed table
    for (int i = 0; i < 3; i++) begin
      do_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wline, tbl[i].rbeats,
             tbl[i].gaps, tbl[i].exp_addr);
      chk("tbl_line_rdata", bus.line_rdata, tbl[i].exp_rdata);
    end

    // Reset during beat 2 of a read
    bus.line_read    = 1'b1;
    bus.line_address = 32'h4444_0010;
    tick;
    bus.burst_resp = 1'b1; bus.burst_rdata = 64'hAAAA_0000_0000_0001;
    tick;
    bus.burst_rdata = 64'hAAAA_0000_0000_0002;
    tick;
    bus.burst_rdata = 64'hAAAA_0000_0000_0003;
    chk("pre_rst_burst_read", bus.burst_read, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_burst_read", bus.burst_read, 0);
    chk("async_rst_line_resp", bus.line_resp, 0);
    chk("async_rst_line_rdata", bus.line_rdata, 0);
    bus.line_read  = 1'b0;
    bus.burst_resp = 1'b0;
    model_rdata    = '0;
    tick;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_line_resp", bus.line_resp, 0);
      chk("post_rst_burst_read", bus.burst_read, 0);
    end
    do_txn(1'b1, 1'b0, 32'h4444_0010,
           '0, {64'h0D, 64'h0C, 64'h0B, 64'h0A}, 16'h0000, 32'h4444_0000);

    // Back-to-back read then write (second request in cycle after line_resp)
    do_txn(1'b1, 1'b0, 32'hCAFE_0020, '0,
           {64'h0404, 64'h0303, 64'h0202, 64'h0101}, 16'h0000, 32'hCAFE_0020);
    do_txn(1'b0, 1'b1, 32'hCAFE_0040, {8{32'h600D_F00D}},
           {4{64'h0}}, 16'h0000, 32'hCAFE_0040);

`ifdef L2_ADAPTOR_TIMEOUT_EN
    begin
      int cyc;
      bus.line_read    = 1'b1;
      bus.line_address = 32'h0000_0100;
      bus.burst_resp   = 1'b0;
      tick;
      cyc = 1;
      while (cyc <= 20 && !bus.line_resp) begin
        tick;
        cyc++;
      end
      chk("timeout_cycle", cyc, 9);
      chk("timeout_flag", bus.burst_timeout, 1);
      chk("timeout_rdata", bus.line_rdata, model_rdata);
      bus.line_read = 1'b0;
      tick;
      chk("timeout_flag_clr", bus.burst_timeout, 0);
      chk("timeout_resp_clr", bus.line_resp, 0);
    end
`endif

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      ra = $urandom;
      for (int k = 0; k < 8; k++) rl[k*32 +: 32] = $urandom;
      for (int k = 0; k < 4; k++) begin
        rb[k] = {$urandom, $urandom};
        gp[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 3));
      end
      do_txn(op != 1, op != 0, ra, rl, rb, gp, ra & 32'hFFFF_FFE0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
